// File: rtl/alu_pkg.sv
// Shared definitions for the ALU family: opcode encoding, shifter control and
// the signed-overflow rule used by both the legacy and the pipelined ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_SRL = 5'b00110;
    localparam logic [4:0] OP_XOR = 5'b00111;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRA = 2'd1,
        SH_SRL = 2'd2
    } shift_kind_t;

    // Two's-complement overflow from the operand and result sign bits.
    function automatic logic signed_ovf(input logic i_sub,
                                        input logic i_a_msb,
                                        input logic i_b_msb,
                                        input logic i_r_msb);
        if (i_sub) begin
            return (i_a_msb != i_b_msb) && (i_r_msb != i_a_msb);
        end
        return (i_a_msb == i_b_msb) && (i_r_msb != i_a_msb);
    endfunction

endpackage

// File: rtl/alu_pipe_shift.sv
// Two-level barrel shifter: byte-granular coarse shift before the S1 register,
// bit-granular fine shift (0..7) after it, feeding the S2 result mux.
module alu_pipe_shift
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clock,
    input  logic              i_load,
    input  shift_kind_t       i_kind,
    input  logic [SHW-1:0]    i_shamt,
    input  logic [WIDTH-1:0]  i_a,
    output logic [WIDTH-1:0]  o_result
);

    logic [SHW-1:0]   w_coarse_amt;
    logic [WIDTH-1:0] w_coarse;
    logic [WIDTH-1:0] r_coarse;
    logic [2:0]       r_fine_amt;
    shift_kind_t      r_kind;

    // Clearing the low three bits leaves the multiple-of-8 part of the amount.
    assign w_coarse_amt = i_shamt & ~SHW'(7);

    always_comb begin
        w_coarse = i_a;
        case (i_kind)
            SH_SLL:  w_coarse = i_a << w_coarse_amt;
            SH_SRA:  w_coarse = $signed(i_a) >>> w_coarse_amt;
            default: w_coarse = i_a >> w_coarse_amt;
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_load) begin
            r_coarse   <= w_coarse;
            r_fine_amt <= i_shamt[2:0];
            r_kind     <= i_kind;
        end
    end

    // The coarse result keeps A's sign bit for SRA, so the fine stage refills correctly.
    always_comb begin
        o_result = r_coarse;
        case (r_kind)
            SH_SLL:  o_result = r_coarse << r_fine_amt;
            SH_SRA:  o_result = $signed(r_coarse) >>> r_fine_amt;
            default: o_result = r_coarse >> r_fine_amt;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, tag pass-through
// and a sticky overflow flag that latches on retired overflowing results.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [SHW-1:0]    in_shamt,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic              out_ne,
    output logic              out_lt,
    output logic              out_ovf,
    output logic              out_illegal,
    output logic [TAGW-1:0]   out_tag,
    output logic              ovf_sticky,
    input  logic              ovf_clear
);

    logic              w_s2_free;
    logic              w_accept;
    logic              w_retire;
    logic [WIDTH-1:0]  w_sum;
    logic [WIDTH-1:0]  w_diff;
    logic              w_add_ovf;
    logic              w_sub_ovf;
    logic [WIDTH-1:0]  w_alu;
    logic              w_ovf;
    logic              w_illegal;
    logic              w_is_shift;
    shift_kind_t       w_kind;
    logic [WIDTH-1:0]  w_shift_result;

    logic              r_s1_valid;
    logic [WIDTH-1:0]  r_s1_alu;
    logic              r_s1_ne;
    logic              r_s1_lt;
    logic              r_s1_ovf;
    logic              r_s1_illegal;
    logic              r_s1_is_shift;
    logic [TAGW-1:0]   r_s1_tag;

    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_out_result;
    logic              r_out_ne;
    logic              r_out_lt;
    logic              r_out_ovf;
    logic              r_out_illegal;
    logic [TAGW-1:0]   r_out_tag;
    logic              r_ovf_sticky;

    assign w_s2_free = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && in_ready;
    assign w_retire  = r_s2_valid && out_ready;

    assign w_sum     = in_a + in_b;
    assign w_diff    = in_a - in_b;
    assign w_add_ovf = signed_ovf(1'b0, in_a[WIDTH-1], in_b[WIDTH-1], w_sum[WIDTH-1]);
    assign w_sub_ovf = signed_ovf(1'b1, in_a[WIDTH-1], in_b[WIDTH-1], w_diff[WIDTH-1]);

    always_comb begin
        w_alu      = '0;
        w_ovf      = 1'b0;
        w_illegal  = 1'b0;
        w_is_shift = 1'b0;
        w_kind     = SH_SLL;
        case (in_opcode)
            OP_ADD: begin
                w_alu = w_sum;
                w_ovf = w_add_ovf;
            end
            OP_SUB: begin
                w_alu = w_diff;
                w_ovf = w_sub_ovf;
            end
            OP_AND: w_alu = in_a & in_b;
            OP_OR:  w_alu = in_a | in_b;
            OP_XOR: w_alu = in_a ^ in_b;
            OP_SLL: begin
                w_is_shift = 1'b1;
                w_kind     = SH_SLL;
            end
            OP_SRA: begin
                w_is_shift = 1'b1;
                w_kind     = SH_SRA;
            end
            OP_SRL: begin
                w_is_shift = 1'b1;
                w_kind     = SH_SRL;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    alu_pipe_shift #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shift (
        .clock    (clock),
        .i_load   (w_accept),
        .i_kind   (w_kind),
        .i_shamt  (in_shamt),
        .i_a      (in_a),
        .o_result (w_shift_result)
    );

    // S1 only reloads on an accept, so a held entry is never overwritten.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_alu      <= w_alu;
                r_s1_ne       <= |w_diff;
                r_s1_lt       <= w_diff[WIDTH-1] ^ w_sub_ovf;
                r_s1_ovf      <= w_ovf;
                r_s1_illegal  <= w_illegal;
                r_s1_is_shift <= w_is_shift;
                r_s1_tag      <= in_tag;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s2_valid    <= 1'b0;
            r_out_result  <= '0;
            r_out_ne      <= 1'b0;
            r_out_lt      <= 1'b0;
            r_out_ovf     <= 1'b0;
            r_out_illegal <= 1'b0;
            r_out_tag     <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result  <= r_s1_is_shift ? w_shift_result : r_s1_alu;
                r_out_ne      <= r_s1_ne;
                r_out_lt      <= r_s1_lt;
                r_out_ovf     <= r_s1_ovf;
                r_out_illegal <= r_s1_illegal;
                r_out_tag     <= r_s1_tag;
            end
        end
    end

    // Clear wins over a same-cycle retire; a stalled result never sets the flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf_sticky <= 1'b0;
        end else if (ovf_clear) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_retire && r_out_ovf) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_result  = r_out_result;
    assign out_ne      = r_out_ne;
    assign out_lt      = r_out_lt;
    assign out_ovf     = r_out_ovf;
    assign out_illegal = r_out_illegal;
    assign out_tag     = r_out_tag;
    assign ovf_sticky  = r_ovf_sticky;

endmodule
